// File: rtl/minesweeper_pkg.sv
// Shared types for the minesweeper command path: FSM states, command codes,
// cell bit positions and the per-axis cursor step request.
package minesweeper_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE_RD  = 3'd1,
    ISSUE   = 3'd2,
    POST_RD = 3'd3,
    EVAL    = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic {
    CMD_OPEN = 1'b0,
    CMD_FLAG = 1'b1
  } cmd_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_DEC  = 2'd1,
    STEP_INC  = 2'd2
  } step_t;

  localparam int MINE_BIT    = 4;
  localparam int OPENED_BIT  = 0;
  localparam int FLAGGED_BIT = 1;

endpackage

// File: rtl/player_ctrl_if.sv
// Button, board read-back and command signals between player_ctrl (master)
// and its surroundings (slave: debouncers, board, board_cover).
interface player_ctrl_if #(
  parameter int x_coord_bits = 4,
  parameter int y_coord_bits = 4
);
  logic                                 btn_up;
  logic                                 btn_down;
  logic                                 btn_left;
  logic                                 btn_right;
  logic                                 btn_open;
  logic                                 btn_flag;
  logic [4:0]                           cell_val_board;
  logic [1:0]                           cell_val_cover;
  logic [x_coord_bits+y_coord_bits-1:0] num_mines;
  logic [x_coord_bits-1:0]              x_coord;
  logic [y_coord_bits-1:0]              y_coord;
  logic                                 open;
  logic                                 flag;
  logic                                 busy;
  logic                                 game_over;
  logic                                 game_won;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_open, btn_flag,
    input  cell_val_board, cell_val_cover, num_mines,
    output x_coord, y_coord, open, flag, busy, game_over, game_won
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_open, btn_flag,
    output cell_val_board, cell_val_cover, num_mines,
    input  x_coord, y_coord, open, flag, busy, game_over, game_won
  );
endinterface

// File: rtl/cursor_step.sv
// Next cursor position on one axis. Saturates at 0 and SIZE-1 by default;
// wraps around when PLAYER_CTRL_WRAP_EN is defined.
module cursor_step
  import minesweeper_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int W    = 4
) (
  input  logic [W-1:0] i_pos,
  input  step_t        i_step,
  output logic [W-1:0] o_pos
);

`ifdef PLAYER_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [W-1:0] MAX_POS = W'(SIZE - 1);

  always_comb begin
    o_pos = i_pos;
    case (i_step)
      STEP_DEC: begin
        if (i_pos == '0) o_pos = WRAP ? MAX_POS : '0;
        else             o_pos = i_pos - W'(1);
      end
      // >= keeps non-power-of-two sizes in range
      STEP_INC: begin
        if (i_pos >= MAX_POS) o_pos = WRAP ? '0 : MAX_POS;
        else                  o_pos = i_pos + W'(1);
      end
      default: o_pos = i_pos;
    endcase
  end

endmodule

// File: rtl/player_ctrl.sv
// Minesweeper player controller: cursor moves, guarded open/flag commands and
// game-over / win tracking. Optional macro PLAYER_CTRL_WRAP_EN (edge wrap).
module player_ctrl
  import minesweeper_pkg::*;
#(
  parameter int x_size       = 16,
  parameter int y_size       = 16,
  parameter int x_coord_bits = 4,
  parameter int y_coord_bits = 4,
  parameter int READ_LAT     = 1
) (
  input  logic          clk,
  input  logic          reset,
  player_ctrl_if.master bus
);

  localparam int                CNT_W     = x_coord_bits + y_coord_bits + 1;
  localparam logic [CNT_W-1:0]  N_CELLS   = CNT_W'(x_size * y_size);
  localparam logic [1:0]        PRE_WAIT  = 2'(READ_LAT - 1);
  localparam logic [1:0]        POST_WAIT = 2'(READ_LAT);

  state_t                  r_state;
  cmd_t                    r_cmd;
  logic [1:0]              r_wait;
  logic [CNT_W-1:0]        r_opened_cnt;
  logic [x_coord_bits-1:0] r_x;
  logic [y_coord_bits-1:0] r_y;
  logic                    r_open;
  logic                    r_flag;
  logic                    r_busy;
  logic                    r_game_over;
  logic                    r_game_won;

  step_t                   w_x_step;
  step_t                   w_y_step;
  logic [x_coord_bits-1:0] w_x_next;
  logic [y_coord_bits-1:0] w_y_next;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [CNT_W-1:0]        w_safe_cells;
  logic                    w_unused_nbr;

  // Move decode; any open/flag pulse suppresses moves in the same cycle.
  always_comb begin
    w_x_step = STEP_HOLD;
    w_y_step = STEP_HOLD;
    if (!bus.btn_open && !bus.btn_flag) begin
      if      (bus.btn_up)    w_y_step = STEP_DEC;
      else if (bus.btn_down)  w_y_step = STEP_INC;
      else if (bus.btn_left)  w_x_step = STEP_DEC;
      else if (bus.btn_right) w_x_step = STEP_INC;
    end
  end

  cursor_step #(.SIZE(x_size), .W(x_coord_bits)) u_x_step (
    .i_pos (r_x),
    .i_step(w_x_step),
    .o_pos (w_x_next)
  );

  cursor_step #(.SIZE(y_size), .W(y_coord_bits)) u_y_step (
    .i_pos (r_y),
    .i_step(w_y_step),
    .o_pos (w_y_next)
  );

  assign w_cnt_inc    = r_opened_cnt + CNT_W'(1);
  assign w_safe_cells = N_CELLS - CNT_W'(bus.num_mines);
  assign w_unused_nbr = ^bus.cell_val_board[3:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cmd        <= CMD_OPEN;
      r_wait       <= '0;
      r_opened_cnt <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_open       <= 1'b0;
      r_flag       <= 1'b0;
      r_busy       <= 1'b0;
      r_game_over  <= 1'b0;
      r_game_won   <= 1'b0;
    end else begin
      r_open <= 1'b0;
      r_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.btn_open || bus.btn_flag) begin
            r_cmd   <= bus.btn_open ? CMD_OPEN : CMD_FLAG;
            r_busy  <= 1'b1;
            r_wait  <= PRE_WAIT;
            r_state <= PRE_RD;
          end else begin
            r_x <= w_x_next;
            r_y <= w_y_next;
          end
        end
        PRE_RD: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 2'd1;
          end else if (bus.cell_val_cover[OPENED_BIT] ||
                       (r_cmd == CMD_OPEN && bus.cell_val_cover[FLAGGED_BIT])) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_open  <= (r_cmd == CMD_OPEN);
            r_flag  <= (r_cmd == CMD_FLAG);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_wait  <= POST_WAIT;
          r_state <= POST_RD;
        end
        // Wait for board_cover to reflect the issued command before judging it.
        POST_RD: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 2'd1;
          end else if (r_cmd == CMD_OPEN) begin
            r_state <= EVAL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        EVAL: begin
          r_busy <= 1'b0;
          if (bus.cell_val_cover[OPENED_BIT] && bus.cell_val_board[MINE_BIT]) begin
            r_game_over <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_opened_cnt <= w_cnt_inc;
            if (w_cnt_inc == w_safe_cells) begin
              r_game_won <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.x_coord   = r_x;
  assign bus.y_coord   = r_y;
  assign bus.open      = r_open;
  assign bus.flag      = r_flag;
  assign bus.busy      = r_busy;
  assign bus.game_over = r_game_over;
  assign bus.game_won  = r_game_won;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: a board/board_cover environment, a
// cell-level reference model, and a monitor matching open/flag pulses.
module tb_player_ctrl;

  localparam int XS = 16;
  localparam int YS = 16;
  localparam int XB = 4;
  localparam int YB = 4;
  localparam int RL = 1;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_OPEN = 4, B_FLAG = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  player_ctrl_if #(.x_coord_bits(XB), .y_coord_bits(YB)) bus ();

  player_ctrl #(
    .x_size(XS), .y_size(YS), .x_coord_bits(XB), .y_coord_bits(YB), .READ_LAT(RL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Environment: board_cover state updated only by DUT pulses, registered reads.
  bit         mines     [YS][XS];
  logic [1:0] env_cover [YS][XS];
  logic [1:0] cov_pipe  [RL];
  logic [4:0] brd_pipe  [RL];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int y = 0; y < YS; y++)
        for (int x = 0; x < XS; x++)
          env_cover[y][x] <= 2'b00;
    end else begin
      if (bus.open) env_cover[bus.y_coord][bus.x_coord][0] <= 1'b1;
      if (bus.flag) env_cover[bus.y_coord][bus.x_coord][1] <= ~env_cover[bus.y_coord][bus.x_coord][1];
    end
  end

  always @(posedge clk) begin
    cov_pipe[0] <= env_cover[bus.y_coord][bus.x_coord];
    brd_pipe[0] <= {mines[bus.y_coord][bus.x_coord], 4'd0};
    for (int i = 1; i < RL; i++) begin
      cov_pipe[i] <= cov_pipe[i-1];
      brd_pipe[i] <= brd_pipe[i-1];
    end
  end

  assign bus.cell_val_cover = cov_pipe[RL-1];
  assign bus.cell_val_board = brd_pipe[RL-1];

  // Reference model
  bit m_opened [YS][XS];
  bit m_flagged[YS][XS];
  int m_x, m_y, m_cnt, m_mines;
  bit m_over, m_won;

  typedef struct {
    bit is_flag;
    int x;
    int y;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int step_dn(input int v, input int size);
`ifdef PLAYER_CTRL_WRAP_EN
    return (v == 0) ? size - 1 : v - 1;
`else
    return (v == 0) ? 0 : v - 1;
`endif
  endfunction

  function automatic int step_up(input int v, input int size);
`ifdef PLAYER_CTRL_WRAP_EN
    return (v + 1) % size;
`else
    return (v + 1 > size - 1) ? size - 1 : v + 1;
`endif
  endfunction

  task automatic model_clear();
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++) begin
        m_opened[y][x]  = 1'b0;
        m_flagged[y][x] = 1'b0;
      end
    m_x = 0; m_y = 0; m_cnt = 0; m_over = 1'b0; m_won = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [5:0] m);
    if (m_over || m_won) return;
    if (m[B_OPEN]) begin
      if (!m_opened[m_y][m_x] && !m_flagged[m_y][m_x]) begin
        exp_q.push_back('{is_flag: 1'b0, x: m_x, y: m_y});
        m_opened[m_y][m_x] = 1'b1;
        if (mines[m_y][m_x]) m_over = 1'b1;
        else begin
          m_cnt++;
          if (m_cnt == XS * YS - m_mines) m_won = 1'b1;
        end
      end
    end else if (m[B_FLAG]) begin
      if (!m_opened[m_y][m_x]) begin
        exp_q.push_back('{is_flag: 1'b1, x: m_x, y: m_y});
        m_flagged[m_y][m_x] = ~m_flagged[m_y][m_x];
      end
    end else if (m[B_UP])    m_y = step_dn(m_y, YS);
    else if (m[B_DOWN])      m_y = step_up(m_y, YS);
    else if (m[B_LEFT])      m_x = step_dn(m_x, XS);
    else if (m[B_RIGHT])     m_x = step_up(m_x, XS);
  endtask

  // Monitor: every open/flag pulse must match the oldest expected command.
  always @(negedge clk) begin
    if (reset && (bus.open || bus.flag)) begin
      check("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_flag", int'(bus.flag), int'(mon_e.is_flag));
        check("pulse_single", int'(bus.open & bus.flag), 0);
        check("pulse_x", int'(bus.x_coord), mon_e.x);
        check("pulse_y", int'(bus.y_coord), mon_e.y);
      end
    end
  end

  task automatic drive(input logic [5:0] m);
    bus.btn_up    = m[B_UP];
    bus.btn_down  = m[B_DOWN];
    bus.btn_left  = m[B_LEFT];
    bus.btn_right = m[B_RIGHT];
    bus.btn_open  = m[B_OPEN];
    bus.btn_flag  = m[B_FLAG];
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", int'(bus.busy), 0);
  endtask

  task automatic press(input logic [5:0] m);
    model_apply(m);
    @(negedge clk);
    drive(m);
    @(negedge clk);
    drive(6'd0);
    wait_idle();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_x"},    int'(bus.x_coord),   m_x);
    check({tag, "_y"},    int'(bus.y_coord),   m_y);
    check({tag, "_over"}, int'(bus.game_over), int'(m_over));
    check({tag, "_won"},  int'(bus.game_won),  int'(m_won));
  endtask

  task automatic goto_xy(input int tx, input int ty);
    while (m_x < tx) press(6'(1 << B_RIGHT));
    while (m_x > tx) press(6'(1 << B_LEFT));
    while (m_y < ty) press(6'(1 << B_DOWN));
    while (m_y > ty) press(6'(1 << B_UP));
    check_state("goto");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"},    int'(bus.x_coord),   0);
    check({tag, "_y"},    int'(bus.y_coord),   0);
    check({tag, "_open"}, int'(bus.open),      0);
    check({tag, "_flag"}, int'(bus.flag),      0);
    check({tag, "_busy"}, int'(bus.busy),      0);
    check({tag, "_over"}, int'(bus.game_over), 0);
    check({tag, "_won"},  int'(bus.game_won),  0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(6'd0);
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_board(input int density);
    m_mines = 0;
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++) begin
        mines[y][x] = ($urandom_range(0, density - 1) == 0);
        if (mines[y][x]) m_mines++;
      end
    if (m_mines > 255) begin
      mines[0][0] = 1'b0;
      m_mines--;
    end
    bus.num_mines = 8'(m_mines);
  endtask

  initial begin
    watchdog();
  end

  task automatic watchdog();
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  endtask

  initial begin
    logic [5:0] m;
    int open_at, n_open, n_busy;

    drive(6'd0);
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++)
        mines[y][x] = 1'b0;
    mines[0][1] = 1'b1;
    m_mines = 1;
    bus.num_mines = 8'd1;
    model_clear();

    // Reset state, held and released
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_rel");

    // Moves and edges
    press(6'(1 << B_LEFT));
    press(6'(1 << B_UP));
    check_state("edge_lo");
    for (int i = 0; i < 20; i++) press(6'(1 << B_RIGHT));
    check_state("edge_hi_x");
    for (int i = 0; i < 20; i++) press(6'(1 << B_DOWN));
    check_state("edge_hi_y");
    for (int i = 0; i < 20; i++) press(6'(1 << B_LEFT));
    press(6'(1 << B_LEFT));
    check_state("edge_left_at0");

    // Simultaneous buttons at (3,3), plus a move dropped while busy
    goto_xy(3, 3);
    model_apply(6'((1 << B_OPEN) | (1 << B_UP) | (1 << B_RIGHT)));
    @(negedge clk);
    drive(6'((1 << B_OPEN) | (1 << B_UP) | (1 << B_RIGHT)));
    @(negedge clk);
    drive(6'd0);
    open_at = -1; n_open = 0; n_busy = 0;
    for (int s = 1; s <= 10; s++) begin
      if (bus.open) begin n_open++; open_at = s; end
      if (bus.busy) n_busy++;
      drive((s == 3) ? 6'(1 << B_RIGHT) : 6'd0);
      @(negedge clk);
    end
    check("simul_open_count", n_open, 1);
    check("simul_open_cycle", open_at, 2);
    check("simul_busy_cycles", n_busy, 5);
    check_state("simul");

    // Guarded open on a flagged cell, then unflag and open
    goto_xy(2, 2);
    press(6'(1 << B_FLAG));
    press(6'(1 << B_OPEN));
    check_state("guard_flagged");
    press(6'(1 << B_FLAG));
    press(6'(1 << B_OPEN));
    press(6'(1 << B_FLAG));
    press(6'(1 << B_OPEN));
    check_state("guard_opened");

    // Mine hit at (1,0); everything afterwards ignored
    goto_xy(1, 0);
    press(6'(1 << B_OPEN));
    check("mine_over", int'(bus.game_over), 1);
    press(6'(1 << B_RIGHT));
    press(6'(1 << B_DOWN));
    press(6'(1 << B_OPEN));
    press(6'(1 << B_FLAG));
    check_state("after_over");
    check("after_over_busy", int'(bus.busy), 0);

    // Reset while the open command sits in PRE_RD
    do_reset();
    goto_xy(4, 5);
    @(negedge clk);
    drive(6'(1 << B_OPEN));
    @(negedge clk);
    drive(6'd0);
    check("abort_busy_pre_rd", int'(bus.busy), 1);
    reset = 1'b0;
    model_clear();
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_all_zero("abort_after");
    goto_xy(4, 5);
    press(6'(1 << B_OPEN));
    check_state("abort_reopen");

    // Win: only one safe cell on the board
    do_reset();
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++)
        mines[y][x] = 1'b1;
    mines[7][5] = 1'b0;
    m_mines = 255;
    bus.num_mines = 8'd255;
    goto_xy(5, 7);
    press(6'(1 << B_OPEN));
    check("win_won", int'(bus.game_won), 1);
    check("win_over", int'(bus.game_over), 0);
    press(6'(1 << B_LEFT));
    check_state("after_win");

    // Randomized commands against the model
    do_reset();
    set_board(12);
    for (int i = 0; i < 400; i++) begin
      m = 6'(1 << $urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) m = m | 6'($urandom_range(0, 63));
      press(m);
      check_state("rand");
      if (m_over || m_won) begin
        do_reset();
        set_board(12);
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Command initiator for the board/board_cover pair: turns debounced single-cycle button pulses (debouncer SCEN outputs) into cursor moves and open/flag requests.
- Drives x_coord/y_coord/open/flag into board_cover and board.
- Reads back cell_val from both, then tracks game-over and win state.
- Sits between the debouncers and the board arrays in the top level.

Parameters:
- x_size, 16, board width in cells
- y_size, 16, board height in cells
- x_coord_bits, 4, width of x_coord
- y_coord_bits, 4, width of y_coord
- READ_LAT, 1, cycles from a coordinate change to a valid cell_val on both arrays (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_up/btn_down/btn_left/btn_right  in  1 each  single-cycle move pulses
- btn_open  in  1  single-cycle open pulse
- btn_flag  in  1  single-cycle flag-toggle pulse
- cell_val_board  in  5  [4] mine, [3:0] neighbour count
- cell_val_cover  in  2  [0] opened, [1] flagged
- num_mines  in  x_coord_bits+y_coord_bits  mine count from board
- x_coord  out  x_coord_bits  cursor column
- y_coord  out  y_coord_bits  cursor row
- open  out  1  one-cycle open request to board_cover
- flag  out  1  one-cycle flag-toggle request to board_cover
- busy  out  1  high while a command is in flight
- game_over  out  1  sticky; a mine was opened
- game_won  out  1  sticky; all safe cells are opened

Behaviour:
- Reset (async, reset=0): x_coord=0, y_coord=0, open=0, flag=0, busy=0, game_over=0, game_won=0, opened_cnt=0, state=IDLE. Reset mid-command aborts it; no open/flag pulse is emitted after reset asserts.
- States: IDLE, PRE_RD, ISSUE, POST_RD, EVAL, DONE.
- IDLE:
  - Accepts one button per cycle. Priority: open > flag > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
  - A move updates x/y on the next edge and stays in IDLE. up: y-1, down: y+1, left: x-1, right: x+1.
  - open or flag latches the command, sets busy=1 and goes to PRE_RD.
- PRE_RD: waits READ_LAT cycles, then samples cell_val_cover.
  - open on a flagged or already-opened cell: drop the command, return to IDLE, no pulse.
  - flag on an opened cell: drop the command, return to IDLE, no pulse.
  - Otherwise go to ISSUE.
- ISSUE: asserts open or flag for exactly one cycle, then goes to POST_RD.
- POST_RD: waits READ_LAT+1 cycles so board_cover has updated.
- EVAL (open only; flag returns straight to IDLE):
  - If cover[0]=1 and board[4]=1: game_over=1, go to DONE.
  - Else opened_cnt+1. If opened_cnt+1 == x_size*y_size - num_mines: game_won=1, go to DONE. Otherwise return to IDLE.
- busy=1 in every state except IDLE and DONE.
- Button pulses arriving while busy=1 are dropped, not queued.
- DONE: all buttons are ignored; x/y hold; exit only via reset.
- Widths:
  - opened_cnt is x_coord_bits+y_coord_bits+1 bits, so 256 fits.
  - x_size*y_size - num_mines is computed at that width.
  - num_mines is sampled at EVAL time.
- Edges: without WRAP_EN, moves saturate at 0 and at size-1. Coordinates never exceed size-1, including non-power-of-two sizes.
- Open-to-IDLE latency: 1 (accept) + READ_LAT + 1 (ISSUE) + READ_LAT+1 + 1 (EVAL). This is 6 cycles at READ_LAT=1.

Optional Feature:
- Macro: PLAYER_CTRL_WRAP_EN.
- Defined: moves wrap. left at x=0 goes to x_size-1; right at x_size-1 goes to 0. Same for y.
- Undefined: moves saturate at the edges (default).

Decomposition:
- Shared package minesweeper_pkg holds:
  - state encoding localparams (IDLE..DONE)
  - cell bit indices: MINE_BIT=4, OPENED_BIT=0, FLAGGED_BIT=1
  - CMD_OPEN/CMD_FLAG codes
- One natural sub-module: cursor_step. Combinational next-coordinate with wrap/saturate per axis; instantiated once for x and once for y.
- The FSM and opened_cnt stay in player_ctrl.

Test Plan:
- Move/saturate: reset, then btn_left×1 and btn_up×1 -> x=0, y=0. btn_right×20 -> x=15. With PLAYER_CTRL_WRAP_EN, btn_left at x=0 -> x=15.
- Simultaneous buttons: btn_open, btn_up and btn_right pulsed together at (3,3) -> no move. open pulses exactly once, 2 cycles after acceptance; busy=1 for 5 cycles.
- Guarded open: flag (2,2), then open (2,2) -> flag pulses once; the open emits no pulse; opened_cnt unchanged.
- Mine hit: board model has a mine at (1,0); open there -> game_over=1 at EVAL; later pulses ignored; x/y unchanged.
- Win: 4×4 board, num_mines=15; open the single safe cell -> game_won=1, game_over=0.
- Reset mid-command: drop reset during PRE_RD -> open never pulses; all outputs 0; next open works normally.
